// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift left, shift right and parallel load.
// It also provides a registered serial output and a word-framing counter that
// pulses word_done when WIDTH shifts have completed since the last
// load, reset or word boundary.
module shift_reg_univ #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [1:0]                 mode,
  input  logic                       serial_in,
  input  logic [WIDTH-1:0]           par_in,
  output logic [WIDTH-1:0]           par_out,
  output logic                       serial_out,
  output logic [$clog2(WIDTH)-1:0]   shift_cnt,
  output logic                       word_done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeLeft  = 2'b01;
  localparam logic [1:0] ModeRight = 2'b10;
  localparam logic [1:0] ModeLoad  = 2'b11;

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wd_q, wd_d;
  logic             shift;

  // Next-state: data path, serial output capture, word counter and completion pulse.
  always_comb begin
    q_d   = q_q;
    so_d  = so_q;
    cnt_d = cnt_q;
    wd_d  = 1'b0;  // pulse clears on every edge unless a word just completed
    shift = 1'b0;
    if (en) begin
      unique case (mode)
        ModeHold: begin
        end
        ModeLeft: begin
          q_d   = {q_q[WIDTH-2:0], serial_in};
          so_d  = q_q[WIDTH-1];
          shift = 1'b1;
        end
        ModeRight: begin
          q_d   = {serial_in, q_q[WIDTH-1:1]};
          so_d  = q_q[0];
          shift = 1'b1;
        end
        ModeLoad: begin
          q_d   = par_in;
          cnt_d = '0;  // a load restarts framing and suppresses any completion
        end
        default: begin
        end
      endcase
    end
    if (shift) begin
      if (cnt_q == LastCnt) begin
        cnt_d = '0;
        wd_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      so_q  <= 1'b0;
      cnt_q <= '0;
      wd_q  <= 1'b0;
    end else begin
      q_q   <= q_d;
      so_q  <= so_d;
      cnt_q <= cnt_d;
      wd_q  <= wd_d;
    end
  end

  assign par_out    = q_q;
  assign serial_out = so_q;
  assign shift_cnt  = cnt_q;
  assign word_done  = wd_q;

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register. It generalises the fixed 8-bit serial-in/serial-out shifter to a WIDTH-bit register with four modes: hold, shift left, shift right and parallel load. It also adds a clock enable, a parallel output, a registered serial output, and a word-framing counter with a completion pulse. It sits between serial links and word-wide datapaths and serves as SISO, SIPO, PISO or PIPO stage as selected by `mode`.

## Interface
- `WIDTH`, default 8 — register width in bits; legal range ≥ 2. Counter width `CW` = clog2(WIDTH), derived internally, not overridable.
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `en`  in  1  — clock enable; 0 = all state holds (except `word_done`, see below).
- `mode`  in  2  — 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- `serial_in`  in  1  — serial data input.
- `par_in`  in  WIDTH  — parallel load data.
- `par_out`  out  WIDTH  — current register contents `q`.
- `serial_out`  out  1  — registered copy of the bit most recently shifted out.
- `shift_cnt`  out  CW  — shifts since last load/reset/word completion, range 0..WIDTH-1.
- `word_done`  out  1  — one-cycle pulse marking completion of WIDTH shifts.

## Operation
- Reset (`rst`=1, immediate, no clock needed): `q`=0, `serial_out`=0, `shift_cnt`=0, `word_done`=0. Reset dominates `en` and `mode`.
- Shift is defined as `en`=1 and `mode` ∈ {01,10}.
- `en`=1, `mode`=00: `q`, `serial_out` and `shift_cnt` hold.
- `en`=1, `mode`=01: `q` ← {q[WIDTH-2:0], serial_in}; `serial_out` ← old q[WIDTH-1].
- `en`=1, `mode`=10: `q` ← {serial_in, q[WIDTH-1:1]}; `serial_out` ← old q[0].
- `en`=1, `mode`=11: `q` ← `par_in`; `serial_out` holds; `shift_cnt` ← 0.
- `en`=0: `q`, `serial_out` and `shift_cnt` hold regardless of `mode`.
- Counter on a shift:
  - if `shift_cnt` = WIDTH-1, it wraps to 0;
  - otherwise it increments.
  - Left and right shifts both count, and direction may change mid-word without resetting the count.
- `word_done` is registered and recomputed every edge. Its next value is 1 iff that edge is a shift with `shift_cnt` = WIDTH-1; otherwise it is 0.
  - It is high for exactly one cycle per completed word.
  - It clears even when the following cycle has `en`=0.
- Load on the cycle the count would have completed: `shift_cnt` ← 0 and `word_done` ← 0. The load wins.
- Illegal or X `mode` does not exist: all 2-bit encodings are defined.

## Timing
- All outputs are registered; there are no combinational input→output paths.
- `par_out` reflects a load or shift on the edge it occurs (visible the cycle after).
- SISO latency: a bit sampled by shift edge n appears on `serial_out` after shift edge n+WIDTH, i.e. WIDTH+1 shift edges in total. The extra stage comes from the output register.
- PISO: after a load, the first `serial_out` update is on the first shift edge. For mode 01 it carries the loaded MSB.
- SIPO: after WIDTH consecutive shifts from cnt 0, `par_out` holds the full word in the same cycle `word_done`=1.
- Stalls (`en`=0 or `mode`=00) stretch latency by exactly the stall count; no data is lost.
- Reset asserted mid-word: all outputs go to 0 asynchronously. On deassertion the block resumes with cnt 0 at the first edge.

## Test plan
- Reset mid-op: with `q`=8'hA5 and `shift_cnt`=3, pulse `rst` between edges -> `par_out`=00, `serial_out`=0, `shift_cnt`=0 and `word_done`=0 before the next edge.
- Load then PISO left: load 8'hA5, then 8 edges mode 01 with `serial_in`=0 -> `serial_out` sequence 1,0,1,0,0,1,0,1; `word_done`=1 only after the 8th edge; final `par_out`=8'h00.
- SIPO right: from reset, 8 edges mode 10 with `serial_in` = 1,1,0,1,0,0,0,0 -> `par_out`=8'h0B; `word_done` high for exactly one cycle; `shift_cnt`=0.
- SISO latency: mode 01, single 1 on `serial_in` at edge 1, zeros after -> `serial_out`=1 only after edge 9.
- Stall: mid-word at `shift_cnt`=5, hold `en`=0 for 3 cycles with mode 01, then mode 00 for 2 cycles -> `par_out`, `serial_out` and `shift_cnt`=5 unchanged; no `word_done`. Resuming with 3 shifts gives `word_done`=1.
- Load/complete collision: at `shift_cnt`=7 apply mode 11 with `par_in`=8'h3C -> `par_out`=3C, `shift_cnt`=0, `word_done`=0, `serial_out` unchanged.
